// File: rtl/i2s_pkg.sv
// Shared types and sizing helpers for the I2S/TDM serial-audio receive path.
package i2s_pkg;

  typedef enum logic {I2S, TDM} mode_e;
  typedef enum logic {HUNT, RECV} rx_state_e;

  function automatic int frame_bits(input int channels, input int slot_bits);
    return channels * slot_bits;
  endfunction

  function automatic int cnt_width(input int fbits);
    return (fbits > 1) ? $clog2(fbits) : 1;
  endfunction

endpackage

// File: rtl/i2s_frame_hold.sv
// One-entry holding register with valid/ready handshake; a frame arriving while
// the previous one is still unconsumed is dropped and flagged with an overrun pulse.
module i2s_frame_hold
  import i2s_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         sclk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_overrun;
  logic         w_blocked;

  assign w_blocked = r_valid & ~i_ready;

  // A load in the same cycle as a consume refills the slot without losing valid.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_load & w_blocked;
      if (i_load && !w_blocked) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/i2s_tdm_rx.sv
// Serial-audio receiver for I2S or N-slot TDM framing with frame-alignment
// checking, lock/error reporting and a valid/ready frame output.
module i2s_tdm_rx
  import i2s_pkg::*;
#(
  parameter int    WIDTH     = 16,
  parameter int    SLOT_BITS = 16,
  parameter int    CHANNELS  = 2,
  parameter mode_e MODE      = I2S
) (
  input  logic                      sclk,
  input  logic                      rst,
  input  logic                      ws,
  input  logic                      sdata,
  output logic [CHANNELS*WIDTH-1:0] frame_o,
  output logic                      frame_valid_o,
  input  logic                      frame_ready_i,
  output logic                      locked_o,
  output logic                      error_o,
  output logic                      overrun_o
);

  localparam int FRAME_BITS = frame_bits(CHANNELS, SLOT_BITS);
  localparam int CNT_W      = cnt_width(FRAME_BITS);
  localparam int ASM_W      = CHANNELS * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(SLOT_BITS - 1);

  if (SLOT_BITS < WIDTH) begin : g_bad_slot_bits
    $error("i2s_tdm_rx: SLOT_BITS must be >= WIDTH");
  end
  if (MODE == I2S && CHANNELS != 2) begin : g_bad_i2s_channels
    $error("i2s_tdm_rx: I2S mode requires CHANNELS == 2");
  end

  rx_state_e        r_state, w_state_next;
  logic [CNT_W-1:0] r_bit_cnt, w_cnt_next;
  logic             r_ws_d;
  logic             r_locked, w_locked_next;
  logic             r_error, w_error_next;
  logic             w_frame_done;
  logic [ASM_W-1:0] r_asm, w_asm_next;
  logic             w_rise, w_fall, w_start, w_mid_rise, w_bad_edge;
  int               w_slot, w_sbit;

  assign w_rise     = ws & ~r_ws_d;
  assign w_fall     = ~ws & r_ws_d;
  assign w_start    = (MODE == I2S) ? w_fall : w_rise;
  assign w_mid_rise = (MODE == I2S) & w_rise;
  assign w_bad_edge = (w_start && (r_bit_cnt != LAST_CNT)) ||
                      (w_mid_rise && (r_bit_cnt != MID_CNT));

  // Drop the incoming bit into its channel, MSB first; pad bits past WIDTH are skipped.
  always_comb begin
    w_slot     = int'(r_bit_cnt) / SLOT_BITS;
    w_sbit     = int'(r_bit_cnt) % SLOT_BITS;
    w_asm_next = r_asm;
    if (r_state == RECV && w_sbit < WIDTH) begin
      for (int j = 0; j < ASM_W; j++) begin
        if (j == w_slot * WIDTH + WIDTH - 1 - w_sbit) begin
          w_asm_next[j] = sdata;
        end
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_bit_cnt;
    w_locked_next = r_locked;
    w_error_next  = 1'b0;
    w_frame_done  = 1'b0;
    case (r_state)
      HUNT: begin
        w_locked_next = 1'b0;
        if (w_start) begin
          w_state_next = RECV;
          w_cnt_next   = '0;
        end
      end
      RECV: begin
        if (w_bad_edge) begin
          w_error_next  = 1'b1;
          w_locked_next = 1'b0;
          w_cnt_next    = '0;
        end else if (w_start) begin
          w_frame_done  = 1'b1;
          w_locked_next = 1'b1;
          w_cnt_next    = '0;
        end else if (r_bit_cnt == LAST_CNT) begin
          w_error_next  = 1'b1;
          w_locked_next = 1'b0;
          w_cnt_next    = '0;
          w_state_next  = HUNT;
        end else begin
          w_cnt_next = r_bit_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = HUNT;
    endcase
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_state   <= HUNT;
      r_bit_cnt <= '0;
      r_ws_d    <= 1'b0;
      r_locked  <= 1'b0;
      r_error   <= 1'b0;
      r_asm     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_cnt_next;
      r_ws_d    <= ws;
      r_locked  <= w_locked_next;
      r_error   <= w_error_next;
      r_asm     <= w_asm_next;
    end
  end

  i2s_frame_hold #(.W(ASM_W)) u_hold (
    .sclk      (sclk),
    .rst       (rst),
    .i_load    (w_frame_done),
    .i_data    (w_asm_next),
    .i_ready   (frame_ready_i),
    .o_data    (frame_o),
    .o_valid   (frame_valid_o),
    .o_overrun (overrun_o)
  );

  assign locked_o = r_locked;
  assign error_o  = r_error;

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Scoreboard bench for i2s_tdm_rx: one I2S instance (2x16) and one TDM instance
// (4 slots of 32 bits, 24-bit samples) share a clock and a reset.
module tb_i2s_tdm_rx;
  import i2s_pkg::*;

  logic        sclk = 1'b0;
  logic        rst  = 1'b0;
  logic        ws0 = 1'b0, sd0 = 1'b0, rdy0 = 1'b1;
  logic [31:0] fo0;
  logic        fv0, lk0, er0, ov0;
  logic        ws1 = 1'b0, sd1 = 1'b0, rdy1 = 1'b1;
  logic [95:0] fo1;
  logic        fv1, lk1, er1, ov1;

  logic [31:0] q0[$];
  logic [95:0] q1[$];
  logic [31:0] exp0;
  logic [95:0] exp1;
  int checks = 0, failures = 0;
  int err_cnt0 = 0, ovr_cnt0 = 0, err_cnt1 = 0;

  i2s_tdm_rx #(.WIDTH(16), .SLOT_BITS(16), .CHANNELS(2), .MODE(I2S)) u_i2s (
    .sclk(sclk), .rst(rst), .ws(ws0), .sdata(sd0),
    .frame_o(fo0), .frame_valid_o(fv0), .frame_ready_i(rdy0),
    .locked_o(lk0), .error_o(er0), .overrun_o(ov0)
  );

  i2s_tdm_rx #(.WIDTH(24), .SLOT_BITS(32), .CHANNELS(4), .MODE(TDM)) u_tdm (
    .sclk(sclk), .rst(rst), .ws(ws1), .sdata(sd1),
    .frame_o(fo1), .frame_valid_o(fv1), .frame_ready_i(rdy1),
    .locked_o(lk1), .error_o(er1), .overrun_o(ov1)
  );

  always #5 sclk = ~sclk;

  // Pops the expected frame whenever the consumer takes one; counts pulse outputs.
  always @(negedge sclk) begin
    if (rst) begin
      if (er0) err_cnt0++;
      if (ov0) ovr_cnt0++;
      if (er1) err_cnt1++;
      if (fv0 && rdy0) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL i2s_unexpected_frame got=%h required=none", fo0);
        end else begin
          exp0 = q0.pop_front();
          if (fo0 !== exp0) begin
            failures++;
            $display("FAIL i2s_frame got=%h required=%h", fo0, exp0);
          end
        end
      end
      if (fv1 && rdy1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL tdm_unexpected_frame got=%h required=none", fo1);
        end else begin
          exp1 = q1.pop_front();
          if (fo1 !== exp1) begin
            failures++;
            $display("FAIL tdm_frame got=%h required=%h", fo1, exp1);
          end
        end
      end
    end
  end

  task automatic drive_i2s(input logic w, input logic d);
    ws0 = w;
    sd0 = d;
    @(posedge sclk); #1;
  endtask

  task automatic drive_tdm(input logic w, input logic d);
    ws1 = w;
    sd1 = d;
    @(posedge sclk); #1;
  endtask

  task automatic sync_i2s();
    drive_i2s(1'b1, 1'b0);
    drive_i2s(1'b0, 1'b0);
  endtask

  task automatic send_i2s(input logic [15:0] l, input logic [15:0] r,
                          input int rise_at, input int last_ready);
    logic [15:0] word;
    for (int i = 0; i < 32; i++) begin
      word = (i < 16) ? l : r;
      if (i == 31 && last_ready >= 0) rdy0 = (last_ready != 0);
      drive_i2s((i >= rise_at) && (i <= 30), word[4'(15 - (i % 16))]);
    end
  endtask

  task automatic send_tdm(input logic [23:0] s0, input logic [23:0] s1,
                          input logic [23:0] s2, input logic [23:0] s3,
                          input int hold_high);
    logic [23:0] sl [4];
    int b;
    sl[0] = s0; sl[1] = s1; sl[2] = s2; sl[3] = s3;
    for (int i = 0; i < 128; i++) begin
      b = i % 32;
      drive_tdm((i == 127) || (i < hold_high),
                (b < 24) ? sl[2'(i / 32)][5'(23 - b)] : 1'b1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ws0 = 1'b0; sd0 = 1'b0; rdy0 = 1'b1;
    ws1 = 1'b0; sd1 = 1'b0; rdy1 = 1'b1;
    @(posedge sclk); #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge sclk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++; if (fo0 !== 32'h0) begin failures++; $display("FAIL reset_i2s_frame got=%h required=0", fo0); end
    checks++; if ({fv0, lk0, er0, ov0} !== 4'b0) begin failures++; $display("FAIL reset_i2s_flags got=%b required=0000", {fv0, lk0, er0, ov0}); end
    checks++; if (fo1 !== 96'h0) begin failures++; $display("FAIL reset_tdm_frame got=%h required=0", fo1); end
    checks++; if ({fv1, lk1, er1, ov1} !== 4'b0) begin failures++; $display("FAIL reset_tdm_flags got=%b required=0000", {fv1, lk1, er1, ov1}); end
    @(posedge sclk); #1;
    rst = 1'b1;
    @(posedge sclk); #1;
  endtask

  task automatic test_i2s_basic();
    int e;
    logic [15:0] l, r;
    do_reset();
    e = err_cnt0;
    sync_i2s();
    checks++; if (lk0 !== 1'b0) begin failures++; $display("FAIL basic_unlocked_before got=%b required=0", lk0); end
    q0.push_back(32'hbeef_dead);
    send_i2s(16'hdead, 16'hbeef, 15, -1);
    checks++; if (lk0 !== 1'b1) begin failures++; $display("FAIL basic_locked got=%b required=1", lk0); end
    checks++; if (fv0 !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b required=1", fv0); end
    for (int k = 0; k < 3; k++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      q0.push_back({r, l});
      send_i2s(l, r, 15, -1);
    end
    drive_i2s(1'b0, 1'b0);
    checks++; if (fv0 !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%b required=0", fv0); end
    drive_i2s(1'b0, 1'b0);
    checks++; if (q0.size() != 0) begin failures++; $display("FAIL basic_drained got=%0d required=0", q0.size()); end
    checks++; if (err_cnt0 - e != 0) begin failures++; $display("FAIL basic_errors got=%0d required=0", err_cnt0 - e); end
  endtask

  task automatic test_backpressure();
    int o;
    logic [31:0] a, b, c;
    do_reset();
    o = ovr_cnt0;
    a = $urandom; b = $urandom; c = $urandom;
    rdy0 = 1'b0;
    sync_i2s();
    q0.push_back(a);
    send_i2s(a[15:0], a[31:16], 15, -1);
    send_i2s(b[15:0], b[31:16], 15, -1);
    checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL bp_overrun_pulse got=%b required=1", ov0); end
    checks++; if (fo0 !== a) begin failures++; $display("FAIL bp_frame_held got=%h required=%h", fo0, a); end
    checks++; if (fv0 !== 1'b1) begin failures++; $display("FAIL bp_valid_held got=%b required=1", fv0); end
    q0.push_back(c);
    send_i2s(c[15:0], c[31:16], 15, 1);
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL bp_reload_no_overrun got=%b required=0", ov0); end
    checks++; if (fo0 !== c || fv0 !== 1'b1) begin failures++; $display("FAIL bp_reload got=%h/%b required=%h/1", fo0, fv0, c); end
    drive_i2s(1'b0, 1'b0);
    checks++; if (ovr_cnt0 - o != 1) begin failures++; $display("FAIL bp_overrun_count got=%0d required=1", ovr_cnt0 - o); end
    checks++; if (q0.size() != 0) begin failures++; $display("FAIL bp_drained got=%0d required=0", q0.size()); end
  endtask

  task automatic test_early_edge();
    int e;
    logic [31:0] a, b, c;
    do_reset();
    e = err_cnt0;
    a = $urandom; b = $urandom; c = $urandom;
    sync_i2s();
    q0.push_back(a);
    send_i2s(a[15:0], a[31:16], 15, -1);
    checks++; if (lk0 !== 1'b1) begin failures++; $display("FAIL early_locked_first got=%b required=1", lk0); end
    send_i2s(b[15:0], b[31:16], 9, -1);
    checks++; if (lk0 !== 1'b0) begin failures++; $display("FAIL early_unlocked got=%b required=0", lk0); end
    q0.push_back(c);
    send_i2s(c[15:0], c[31:16], 15, -1);
    checks++; if (lk0 !== 1'b1) begin failures++; $display("FAIL early_relock got=%b required=1", lk0); end
    drive_i2s(1'b0, 1'b0);
    checks++; if (err_cnt0 - e != 2) begin failures++; $display("FAIL early_error_count got=%0d required=2", err_cnt0 - e); end
    checks++; if (q0.size() != 0) begin failures++; $display("FAIL early_drained got=%0d required=0", q0.size()); end
  endtask

  task automatic test_missing_edge();
    int e;
    logic [31:0] a, c;
    do_reset();
    a = $urandom; c = $urandom;
    sync_i2s();
    q0.push_back(a);
    send_i2s(a[15:0], a[31:16], 15, -1);
    e = err_cnt0;
    for (int k = 0; k < 40; k++) drive_i2s(1'b0, 1'($urandom));
    checks++; if (lk0 !== 1'b0) begin failures++; $display("FAIL missing_unlocked got=%b required=0", lk0); end
    checks++; if (err_cnt0 - e != 1) begin failures++; $display("FAIL missing_error_count got=%0d required=1", err_cnt0 - e); end
    sync_i2s();
    q0.push_back(c);
    send_i2s(c[15:0], c[31:16], 15, -1);
    checks++; if (lk0 !== 1'b1) begin failures++; $display("FAIL missing_relock got=%b required=1", lk0); end
    drive_i2s(1'b0, 1'b0);
    checks++; if (q0.size() != 0) begin failures++; $display("FAIL missing_drained got=%0d required=0", q0.size()); end
  endtask

  task automatic test_tdm();
    int e;
    logic [23:0] s0, s1, s2, s3;
    do_reset();
    e = err_cnt1;
    drive_tdm(1'b0, 1'b0);
    drive_tdm(1'b1, 1'b0);
    q1.push_back(96'h800000_000001_abcdef_123456);
    send_tdm(24'h123456, 24'habcdef, 24'h000001, 24'h800000, 0);
    checks++; if (lk1 !== 1'b1) begin failures++; $display("FAIL tdm_locked got=%b required=1", lk1); end
    checks++; if (fv1 !== 1'b1) begin failures++; $display("FAIL tdm_valid got=%b required=1", fv1); end
    s0 = 24'($urandom); s1 = 24'($urandom); s2 = 24'($urandom); s3 = 24'($urandom);
    q1.push_back({s3, s2, s1, s0});
    send_tdm(s0, s1, s2, s3, 3);
    drive_tdm(1'b0, 1'b0);
    drive_tdm(1'b0, 1'b0);
    checks++; if (q1.size() != 0) begin failures++; $display("FAIL tdm_drained got=%0d required=0", q1.size()); end
    checks++; if (err_cnt1 - e != 0) begin failures++; $display("FAIL tdm_errors got=%0d required=0", err_cnt1 - e); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] a, c;
    do_reset();
    a = $urandom; c = $urandom;
    sync_i2s();
    q0.push_back(a);
    send_i2s(a[15:0], a[31:16], 15, -1);
    for (int k = 0; k < 7; k++) drive_i2s(1'b0, 1'($urandom));
    rst = 1'b0;
    #1;
    checks++; if (lk0 !== 1'b0) begin failures++; $display("FAIL midrst_locked got=%b required=0", lk0); end
    checks++; if (fo0 !== 32'h0) begin failures++; $display("FAIL midrst_frame got=%h required=0", fo0); end
    checks++; if ({fv0, er0, ov0} !== 3'b0) begin failures++; $display("FAIL midrst_flags got=%b required=000", {fv0, er0, ov0}); end
    @(posedge sclk); #1;
    rst = 1'b1;
    @(posedge sclk); #1;
    sync_i2s();
    q0.push_back(c);
    send_i2s(c[15:0], c[31:16], 15, -1);
    checks++; if (lk0 !== 1'b1) begin failures++; $display("FAIL midrst_relock got=%b required=1", lk0); end
    drive_i2s(1'b0, 1'b0);
    checks++; if (q0.size() != 0) begin failures++; $display("FAIL midrst_drained got=%0d required=0", q0.size()); end
  endtask

  initial begin
    @(posedge sclk); #1;
    test_reset();
    test_i2s_basic();
    test_backpressure();
    test_early_edge();
    test_missing_edge();
    test_tdm();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
